// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction fetch front-end.
package otter_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with head look-ahead and single-cycle clear; clear wins over push/pop.
module otter_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             push_en;
  logic             pop_en;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/otter_fetch_buffer.sv
// OTTER fetch front-end: in-order imem requests, credit-limited buffering of
// returned words with their PCs, and redirect handling with stale-response drop.
module otter_fetch_buffer
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IF_VALID,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_NEXT_PC,
  input  logic        IF_READY,
  output logic        ERR
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   rsp_pc;
  logic [31:0]   rsp_pc_nxt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] q_cnt;
  logic [CW:0]   credit;
  logic          req_c;
  logic          grant;
  logic          rsp_ok;
  logic          redir_ok;
  logic          redir_bad;
  logic          q_push;
  logic          q_pop;
  logic          q_clear;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  // State and counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      rsp_pc   <= rsp_pc_nxt;
      out_cnt  <= out_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // Next-state, request, credit and queue control; redirect overrides everything.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    rsp_pc_nxt   = rsp_pc;
    out_nxt      = out_cnt;
    drop_nxt     = drop_cnt;
    req_c        = 1'b0;
    grant        = 1'b0;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    q_clear      = 1'b0;
    credit       = {1'b0, out_cnt} + {1'b0, q_cnt};
    rsp_ok       = IMEM_RVALID && (out_cnt != '0);
    redir_ok     = REDIRECT && (state != HALT) && (REDIRECT_PC[1:0] == 2'b00);
    redir_bad    = REDIRECT && (state != HALT) && (REDIRECT_PC[1:0] != 2'b00);

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     req_c = !REDIRECT && (credit < CREDIT_MAX);
      HALT:    q_clear = 1'b1;
      default: state_nxt = BOOT;
    endcase

    grant   = req_c && IMEM_GNT;
    out_nxt = out_cnt + CW'(grant) - CW'(rsp_ok);
    if (grant) fetch_pc_nxt = fetch_pc + 32'd4;

    q_pop = !q_empty && IF_READY;
    if (rsp_ok) begin
      if (drop_cnt != '0) begin
        drop_nxt = drop_cnt - CW'(1);
      end else if (state == RUN) begin
        q_push = !q_full || q_pop;
      end
    end
    if (q_push) rsp_pc_nxt = rsp_pc + 32'd4;

    // Every response still owed after this cycle belongs to the old path.
    if (redir_ok) begin
      q_clear      = 1'b1;
      q_push       = 1'b0;
      q_pop        = 1'b0;
      fetch_pc_nxt = REDIRECT_PC;
      rsp_pc_nxt   = REDIRECT_PC;
      drop_nxt     = out_nxt;
    end

    if (redir_bad) begin
      state_nxt = HALT;
      q_clear   = 1'b1;
      q_push    = 1'b0;
      q_pop     = 1'b0;
    end
  end

  assign q_din = '{pc: rsp_pc, ir: IMEM_RDATA};

  otter_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .clear (q_clear),
    .head  (q_head),
    .count (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  assign IMEM_REQ   = req_c;
  assign IMEM_ADDR  = fetch_pc;
  assign IF_VALID   = !q_empty;
  assign IF_IR      = IF_VALID ? q_head.ir : NOP_INSTR;
  assign IF_PC      = IF_VALID ? q_head.pc : 32'd0;
  assign IF_NEXT_PC = IF_PC + 32'd4;
  assign ERR        = (state == HALT);

endmodule

// File: tb/tb_otter_fetch_buffer.sv
// Directed bench for otter_fetch_buffer with an in-order latency memory model
// and a PC scoreboard of the words decode should accept.
module tb_otter_fetch_buffer;
  import otter_fetch_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'd0;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IF_VALID;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic [31:0] IF_NEXT_PC;
  logic        IF_READY;
  logic        ERR;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          grants = 0;
  int          pops = 0;
  int          mem_lat = 1;
  int unsigned mem_clk = 0;
  logic [31:0] addr_q[$];
  int unsigned due_q[$];
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  otter_fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IF_VALID    (IF_VALID),
    .IF_IR       (IF_IR),
    .IF_PC       (IF_PC),
    .IF_NEXT_PC  (IF_NEXT_PC),
    .IF_READY    (IF_READY),
    .ERR         (ERR)
  );

  // In-order memory: response visible mem_lat cycles after the grant cycle.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q.delete();
      due_q.delete();
      IMEM_RVALID <= 1'b0;
      IMEM_RDATA  <= 32'd0;
    end else begin
      mem_clk = mem_clk + 1;
      if (IMEM_REQ && IMEM_GNT) begin
        addr_q.push_back(IMEM_ADDR);
        due_q.push_back(mem_clk + 32'(mem_lat) - 1);
      end
      if (due_q.size() > 0 && due_q[0] <= mem_clk) begin
        IMEM_RVALID <= 1'b1;
        IMEM_RDATA  <= addr_q[0] ^ XOR_PAT;
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        IMEM_RVALID <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int mem_out();
    return addr_q.size() + (IMEM_RVALID ? 1 : 0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic load_path(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Drive one cycle's inputs, let them settle, then score an accepted head.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    IF_READY    = rdy;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    #1;
    if (IMEM_REQ && IMEM_GNT) grants++;
    if (IF_VALID && IF_READY && !REDIRECT) begin
      check1("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pops++;
        check("if_pc", IF_PC, e);
        check("if_ir", IF_IR, e ^ XOR_PAT);
        check("if_next_pc", IF_NEXT_PC, e + 32'd4);
      end
    end
  endtask

  initial begin
    int req_cyc;
    int first_valid;
    bit found;

    RESET_N = 1'b0; IMEM_GNT = 1'b1; IF_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
    repeat (3) tick();
    #1;
    check1("rst_req", IMEM_REQ, 1'b0);
    check("rst_addr", IMEM_ADDR, RST_PC);
    check1("rst_valid", IF_VALID, 1'b0);
    check("rst_ir", IF_IR, NOP_INSTR);
    check("rst_pc", IF_PC, 32'd0);
    check("rst_next_pc", IF_NEXT_PC, 32'd4);
    check1("rst_err", ERR, 1'b0);

    // Zero-wait stream from reset.
    tick(); RESET_N = 1'b1; load_path(RST_PC, 64);
    step(1'b1, 1'b0, 32'd0);
    check1("boot_no_req", IMEM_REQ, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("first_req", IMEM_REQ, 1'b1);
    check("first_addr", IMEM_ADDR, RST_PC);
    req_cyc = cyc; first_valid = -1; pops = 0;
    for (int i = 0; i < 14; i++) begin
      tick(); step(1'b1, 1'b0, 32'd0);
      if (IF_VALID && first_valid < 0) first_valid = cyc;
    end
    check("fetch_latency", 32'(first_valid - req_cyc), 32'd2);
    check("stream_pops", 32'(pops), 32'd13);

    // Decode hold: one entry queued and one in flight, so two more grants fill the credit.
    grants = 0;
    for (int i = 0; i < 10; i++) begin tick(); step(1'b0, 1'b0, 32'd0); end
    check("hold_grants", 32'(grants), 32'd2);
    check1("hold_req_low", IMEM_REQ, 1'b0);
    check("hold_head_pc", IF_PC, exp_q[0]);
    pops = 0; grants = 0;
    for (int i = 0; i < 8; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    check("release_pops", 32'(pops), 32'd8);
    check1("release_resume", grants > 0, 1'b1);

    // Slow memory, redirect with three fetches outstanding.
    mem_lat = 3; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem_out() == 3) found = 1;
      else step(1'b1, 1'b0, 32'd0);
    end
    check1("o3_reached", found, 1'b1);
    load_path(32'h100, 64);
    step(1'b1, 1'b1, 32'h100);
    check1("redir_req_low", IMEM_REQ, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("redir_req_new", IMEM_REQ, 1'b1);
    check("redir_addr_new", IMEM_ADDR, 32'h100);
    check1("redir_q_empty", IF_VALID, 1'b0);
    pops = 0;
    for (int i = 0; i < 30; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    check1("redir_new_pops", pops >= 4, 1'b1);

    // Zero-wait redirect landing on a cycle with RVALID and an accepted head.
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (IMEM_RVALID && IF_VALID) found = 1;
      else step(1'b1, 1'b0, 32'd0);
    end
    check1("sync_found", found, 1'b1);
    load_path(32'h200, 64);
    step(1'b1, 1'b1, 32'h200);
    check1("sync_req_low", IMEM_REQ, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("sync_n1_empty", IF_VALID, 1'b0);
    check1("sync_n1_req", IMEM_REQ, 1'b1);
    check("sync_n1_addr", IMEM_ADDR, 32'h200);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("sync_n2_empty", IF_VALID, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("sync_n3_valid", IF_VALID, 1'b1);
    for (int i = 0; i < 5; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end

    // Misaligned redirect halts fetch until reset.
    tick(); exp_q.delete(); step(1'b1, 1'b1, 32'h102);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("halt_err", ERR, 1'b1);
    check1("halt_req", IMEM_REQ, 1'b0);
    check1("halt_valid", IF_VALID, 1'b0);
    for (int i = 0; i < 5; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    check1("halt_err_sticky", ERR, 1'b1);
    check1("halt_req_hold", IMEM_REQ, 1'b0);
    check("halt_ir", IF_IR, NOP_INSTR);
    tick(); RESET_N = 1'b0; #1;
    check1("rst2_err", ERR, 1'b0);
    tick(); RESET_N = 1'b1; load_path(RST_PC, 64);
    step(1'b1, 1'b0, 32'd0);
    check1("rst2_boot", IMEM_REQ, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("rst2_req", IMEM_REQ, 1'b1);
    check("rst2_addr", IMEM_ADDR, RST_PC);
    pops = 0;
    for (int i = 0; i < 8; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    check("rst2_pops", 32'(pops), 32'd7);

    // Asynchronous reset between clock edges.
    @(posedge CLK); #3; RESET_N = 1'b0; #1;
    check1("arst_req", IMEM_REQ, 1'b0);
    check("arst_addr", IMEM_ADDR, RST_PC);
    check1("arst_valid", IF_VALID, 1'b0);
    check("arst_ir", IF_IR, NOP_INSTR);
    check("arst_pc", IF_PC, 32'd0);
    check("arst_next_pc", IF_NEXT_PC, 32'd4);
    check1("arst_err", ERR, 1'b0);
    tick(); RESET_N = 1'b1; load_path(RST_PC, 64);
    step(1'b1, 1'b0, 32'd0);
    check1("arst_boot", IMEM_REQ, 1'b0);
    tick(); step(1'b1, 1'b0, 32'd0);
    check1("arst_first_req", IMEM_REQ, 1'b1);
    check("arst_first_addr", IMEM_ADDR, RST_PC);
    pops = 0;
    for (int i = 0; i < 8; i++) begin tick(); step(1'b1, 1'b0, 32'd0); end
    check("arst_pops", 32'(pops), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
